// File: rtl/rate_pkg.sv
// Shared constants for the multi-channel tick generator.
// Standard reload values assume a 50 MHz system clock.
package rate_pkg;

    localparam int CNT_W_DEF = 28;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int unsigned LOAD_60HZ = 833332;
    localparam int unsigned LOAD_1HZ  = 49999999;

    // A single channel still needs a one-bit select field.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_rate_tick_gen_if.sv
// Control and status bundle of the tick generator.
// The game logic is master; the generator is slave.
interface multi_rate_tick_gen_if
    import rate_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEF
);

    localparam int SEL_W = sel_w(NUM_CH);

    logic                      enable;
    logic [NUM_CH-1:0]         ch_en;
    logic [NUM_CH-1:0]         mode;
    logic [NUM_CH-1:0]         restart;
    logic                      load_we;
    logic [SEL_W-1:0]          load_sel;
    logic [CNT_W-1:0]          load_value;
    logic [NUM_CH-1:0]         tick;
    logic [NUM_CH-1:0]         busy;
    logic [NUM_CH*CNT_W-1:0]   count;

    modport master (
        output enable, ch_en, mode, restart,
        output load_we, load_sel, load_value,
        input  tick, busy, count
    );

    modport slave (
        input  enable, ch_en, mode, restart,
        input  load_we, load_sel, load_value,
        output tick, busy, count
    );

endinterface

// File: rtl/tick_channel.sv
// One divider channel: reload register, down counter,
// one-shot busy flag and registered tick.
module tick_channel
    import rate_pkg::*;
#(
    parameter int               CNT_W        = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_LOAD = CNT_W'(LOAD_60HZ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_en,
    input  logic             mode,
    input  logic             restart,
    input  logic             load_we,
    input  logic [CNT_W-1:0] load_value,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] reload_q, reload_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             tick_q, tick_d;
    logic             run;

    always_comb begin
        reload_d = reload_q;
        count_d  = count_q;
        busy_d   = busy_q;
        tick_d   = 1'b0;
        run      = run_en && ((mode == MODE_ONESHOT) ? busy_q : 1'b1);

        if (load_we)
            reload_d = load_value;

        // Restart beats a same-cycle wrap and sees a same-cycle write.
        if (restart) begin
            count_d = reload_d;
            busy_d  = (mode == MODE_ONESHOT);
        end else if (run) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                tick_d = 1'b1;
                if (mode == MODE_ONESHOT)
                    busy_d = 1'b0;
                else
                    count_d = reload_d;
            end
        end

        if (mode == MODE_PERIODIC)
            busy_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reload_q <= DEFAULT_LOAD;
            count_q  <= DEFAULT_LOAD;
            busy_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            reload_q <= reload_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            tick_q   <= tick_d;
        end
    end

    assign tick  = tick_q;
    assign busy  = busy_q;
    assign count = count_q;

endmodule

// File: rtl/multi_rate_tick_gen.sv
// NUM_CH independent programmable tick dividers sharing
// one reload write port.
module multi_rate_tick_gen
    import rate_pkg::*;
#(
    parameter int               NUM_CH       = 4,
    parameter int               CNT_W        = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_LOAD = CNT_W'(LOAD_60HZ)
) (
    input  logic                 clk,
    input  logic                 reset,
    multi_rate_tick_gen_if.slave bus
);

    localparam int SEL_W = sel_w(NUM_CH);

    logic [NUM_CH-1:0]       tick_w;
    logic [NUM_CH-1:0]       busy_w;
    logic [NUM_CH*CNT_W-1:0] count_w;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic we;
        logic run_en;

        // Out-of-range selects match no channel and are dropped.
        assign we     = bus.load_we && (bus.load_sel == SEL_W'(i));
        assign run_en = bus.enable && bus.ch_en[i];

        tick_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_LOAD (DEFAULT_LOAD)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .run_en     (run_en),
            .mode       (bus.mode[i]),
            .restart    (bus.restart[i]),
            .load_we    (we),
            .load_value (bus.load_value),
            .tick       (tick_w[i]),
            .busy       (busy_w[i]),
            .count      (count_w[i*CNT_W +: CNT_W])
        );
    end

    assign bus.tick  = tick_w;
    assign bus.busy  = busy_w;
    assign bus.count = count_w;

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// Directed and randomized bench for multi_rate_tick_gen
// against a cycle-level behavioural model of the channel rules.
module tb_multi_rate_tick_gen;

    localparam int NCH = 3;
    localparam int CW  = 28;
    localparam int DL  = 833332;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multi_rate_tick_gen_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    multi_rate_tick_gen #(
        .NUM_CH       (NCH),
        .CNT_W        (CW),
        .DEFAULT_LOAD (CW'(DL))
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int unsigned m_rl  [NCH];
    int unsigned m_cnt [NCH];
    bit          m_bsy [NCH];
    bit          m_tk  [NCH];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the reference model by one clock using the current inputs.
    task automatic model_step();
        for (int i = 0; i < NCH; i++) begin
            bit run;
            bit oneshot;
            if (reset) begin
                m_rl[i]  = DL;
                m_cnt[i] = DL;
                m_bsy[i] = 0;
                m_tk[i]  = 0;
                continue;
            end
            oneshot = bus.mode[i];
            if (bus.load_we && int'(bus.load_sel) == i)
                m_rl[i] = int'(bus.load_value);
            run = bus.enable && bus.ch_en[i] && (oneshot ? m_bsy[i] : 1'b1);
            m_tk[i] = 0;
            if (bus.restart[i]) begin
                m_cnt[i] = m_rl[i];
                m_bsy[i] = oneshot;
            end else if (run) begin
                if (m_cnt[i] > 0) begin
                    m_cnt[i] = m_cnt[i] - 1;
                end else begin
                    m_tk[i] = 1;
                    if (oneshot) m_bsy[i] = 0;
                    else m_cnt[i] = m_rl[i];
                end
            end
            if (!oneshot) m_bsy[i] = 0;
        end
    endtask

    task automatic step();
        logic [NCH-1:0]    et;
        logic [NCH-1:0]    eb;
        logic [NCH*CW-1:0] ec;
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            et[i] = m_tk[i];
            eb[i] = m_bsy[i];
            ec[i*CW +: CW] = CW'(m_cnt[i]);
        end
        chk("model_tick", bus.tick, et);
        chk("model_busy", bus.busy, eb);
        chk("model_count", bus.count, ec);
    endtask

    function automatic logic [CW-1:0] cnt_of(input int ch);
        return bus.count[ch*CW +: CW];
    endfunction

    initial begin
        int nb;
        int nt;
        int held;
        int guard;
        logic [NCH*CW-1:0] all_dl;

        for (int i = 0; i < NCH; i++) all_dl[i*CW +: CW] = CW'(DL);

        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.ch_en      = '0;
        bus.mode       = '0;
        bus.restart    = '0;
        bus.load_we    = 1'b0;
        bus.load_sel   = '0;
        bus.load_value = '0;
        step();
        step();
        chk("rst_count", bus.count, all_dl);
        chk("rst_tick", bus.tick, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;

        // Periodic with reload 3
        bus.enable     = 1'b1;
        bus.ch_en      = '1;
        bus.load_we    = 1'b1;
        bus.load_sel   = 2'd0;
        bus.load_value = 28'd3;
        bus.restart    = 3'b001;
        step();
        bus.load_we = 1'b0;
        bus.restart = '0;
        chk("p_start", cnt_of(0), 3);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("p_count", cnt_of(0), 3 - (k % 4));
            chk("p_tick", bus.tick[0], (k % 4) == 0);
        end

        // One-shot with reload 5
        bus.mode       = 3'b010;
        bus.load_we    = 1'b1;
        bus.load_sel   = 2'd1;
        bus.load_value = 28'd5;
        step();
        bus.load_we = 1'b0;
        bus.restart = 3'b010;
        step();
        bus.restart = '0;
        nb = int'(bus.busy[1]);
        nt = int'(bus.tick[1]);
        repeat (9) begin
            step();
            nb += int'(bus.busy[1]);
            nt += int'(bus.tick[1]);
        end
        chk("os_busy_cycles", nb, 6);
        chk("os_ticks", nt, 1);
        chk("os_hold0", cnt_of(1), 0);
        bus.restart = 3'b010;
        step();
        bus.restart = '0;
        nt = 0;
        repeat (8) begin
            step();
            nt += int'(bus.tick[1]);
        end
        chk("os_second_tick", nt, 1);

        // Pause mid-count
        guard = 0;
        while (cnt_of(0) != 2 && guard < 10) begin
            step();
            guard++;
        end
        chk("pause_reach", cnt_of(0), 2);
        bus.enable = 1'b0;
        held = int'(cnt_of(0));
        repeat (10) begin
            step();
            chk("pause_hold", cnt_of(0), held);
            chk("pause_notick", bus.tick, 0);
        end
        bus.enable = 1'b1;
        step();
        chk("pause_resume", cnt_of(0), held - 1);

        // Reload update mid-count, then out-of-range select
        bus.load_we    = 1'b1;
        bus.load_sel   = 2'd0;
        bus.load_value = 28'd7;
        bus.restart    = 3'b001;
        step();
        bus.load_we = 1'b0;
        bus.restart = '0;
        for (int k = 1; k <= 20; k++) begin
            bus.load_we = (k == 4) || (k == 15);
            bus.load_sel = (k == 15) ? 2'd3 : 2'd0;
            bus.load_value = (k == 15) ? 28'd1 : 28'd2;
            step();
            chk("rl_tick", bus.tick[0], k >= 8 && ((k - 8) % 3) == 0);
        end
        bus.load_we = 1'b0;

        // Write and restart together, then restart on the wrap cycle
        bus.load_we    = 1'b1;
        bus.load_sel   = 2'd0;
        bus.load_value = 28'd4;
        bus.restart    = 3'b001;
        step();
        bus.load_we = 1'b0;
        bus.restart = '0;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("col_tick", bus.tick[0], k == 5);
        end
        guard = 0;
        while (m_cnt[0] != 0 && guard < 10) begin
            step();
            guard++;
        end
        chk("col_wrap_reach", cnt_of(0), 0);
        bus.restart = 3'b001;
        step();
        bus.restart = '0;
        chk("col_wrap_notick", bus.tick[0], 0);
        chk("col_wrap_count", cnt_of(0), 4);

        // Reset while a one-shot is armed
        bus.restart = 3'b010;
        step();
        bus.restart = '0;
        chk("rst2_armed", bus.busy[1], 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_tick", bus.tick, 0);
        chk("rst2_busy", bus.busy, 0);
        chk("rst2_count", bus.count, all_dl);

        // Reload 0: tick every enabled cycle
        bus.mode       = '0;
        bus.load_we    = 1'b1;
        bus.load_sel   = 2'd0;
        bus.load_value = '0;
        bus.restart    = 3'b001;
        step();
        bus.load_we = 1'b0;
        bus.restart = '0;
        chk("z_restart_notick", bus.tick[0], 0);
        repeat (5) begin
            step();
            chk("z_tick", bus.tick[0], 1);
        end

        // Randomized traffic against the model
        repeat (2000) begin
            reset       = ($urandom_range(0, 499) == 0);
            bus.enable  = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NCH; i++) begin
                bus.ch_en[i]   = ($urandom_range(0, 9) != 0);
                bus.restart[i] = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 49) == 0) bus.mode[i] = ~bus.mode[i];
            end
            bus.load_we    = ($urandom_range(0, 7) == 0);
            bus.load_sel   = 2'($urandom_range(0, 3));
            bus.load_value = 28'($urandom_range(0, 9));
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
